lynx_io: RTL
============

# lynx_io

Z80 I/O port block for the Lynx core, directly downstream of the CPU wrapper. It decodes the CPU's I/O cycles, latches OUT writes to the system control, bank and speaker ports, and returns keyboard matrix data on IN cycles. It also generates the video-frame maskable interrupt that feeds the CPU's active-low interrupt input.

## Interface
- INTLEN, 32: number of `cep` pulses that `int` is held low per frame interrupt (1..255).
- clock  in  1  system clock, same as the CPU.
- reset  in  1  synchronous, active-high reset.
- cep  in  1  CPU positive clock enable; all bus sampling and interrupt counting is qualified by it.
- iorq  in  1  CPU I/O request, active low.
- wr  in  1  CPU write strobe, active low.
- a  in  16  CPU address bus.
- d  in  8  CPU data out.
- q  out  8  data returned to CPU data-in mux on I/O reads.
- vsync  in  1  video vertical sync, active high, synchronous to `clock`.
- int  out  1  interrupt request to CPU, active low.
- kbRow  out  4  keyboard row select.
- kbCol  in  8  keyboard column data, active low.
- reg80  out  8  system control latch (port 0x80).
- reg82  out  8  bank switch latch (port 0x82).
- speaker  out  6  speaker DAC level (port 0x84, bits 5:0).

## Operation
- Decode uses `a[7:0]` only; `a[15:8]` is ignored except for keyboard row select.
- Write strobe `ws`: asserted for exactly one `clock` in a `cep` cycle when `iorq`=0, `wr`=0, and `wr` sampled at the previous `cep` was 1. It is one strobe per OUT, however long the CPU holds the write.
- On `ws`:
  - `a[7:0]`=0x80: `reg80` <= `d`.
  - 0x82: `reg82` <= `d`.
  - 0x84: `speaker` <= `d[5:0]`.
  - Other addresses: no effect.
- Read path, evaluated every `clock`:
  - `kbRow` <= `a[11:8]` when `iorq`=0 and `a[7:0]`=0x80, else it holds.
  - `q` <= `kbCol` when `iorq`=0, `wr`=1 and `a[7:0]`=0x80; otherwise `q` <= 0xFF.
- Interrupt FSM, states IDLE and ACTIVE:
  - IDLE -> ACTIVE on a `vsync` rising edge (registered previous value) when `reg80[0]`=0. Counter loads INTLEN and `int` goes 0.
  - In ACTIVE, each `cep` decrements the counter. When the counter reaches 0 the FSM returns to IDLE and `int` goes 1.
  - A `vsync` rising edge while ACTIVE reloads the counter to INTLEN. `int` stays 0.
  - Writing `reg80[0]`=1 while ACTIVE forces IDLE, with `int`=1 on the next clock.
  - A rising edge and a mask write in the same clock: the mask wins and the FSM goes to IDLE.
- Reset, from any state:
  - `reg80`=0x00, `reg82`=0x00, `speaker`=0, `kbRow`=0, `q`=0xFF, `int`=1, FSM IDLE, counter 0.
  - Previous-`wr` sample = 1, previous-`vsync` sample = 1. This prevents a false strobe or interrupt straight after reset.

## Timing
- Latch outputs update on the clock edge ending the `ws` cycle, so they are visible one clock after the qualifying `cep`.
- `q` has one `clock` latency from `a`/`kbCol`/`iorq`. The CPU samples data-in on a later enable, so this is sufficient.
- `int` falls one clock after the `vsync` edge is detected, i.e. two clocks after `vsync` rises.
- `int` stays low for exactly INTLEN `cep` pulses, not clocks.
- `cep`=0 freezes the write-edge sampler and the interrupt counter. Read-path registers still update.
- Reset asserted mid-OUT: the write is discarded. After release, a write still held low produces no strobe until `wr` has been sampled high.

## Test plan
- Reset check: hold `reset` 4 clocks, with `cep` toggling every 2 clocks, then release.
  - All outputs hold their reset values: `int`=1, `q`=0xFF, latches 0.
- Single write:
  - OUT (0x80),0xA5: `reg80`=0xA5.
  - OUT (0x84),0xFF: `speaker`=0x3F.
  - With `wr` held low for 6 `cep` pulses: exactly one `ws`.
  - OUT to 0x81 leaves all latches unchanged.
- Keyboard read: `a`=0x0380, `iorq`=0, `wr`=1, `kbCol`=0xFE.
  - Next clock: `kbRow`=3, `q`=0xFE.
  - Then `a`=0x0081: `q`=0xFF.
- Interrupt, INTLEN=4: pulse `vsync` high.
  - `int` goes 0 two clocks later and returns to 1 after exactly 4 `cep` pulses.
  - With `reg80[0]`=1, no interrupt occurs.
- Retrigger and mask: second `vsync` edge after 2 `cep` pulses of ACTIVE.
  - `int` stays low for 4 more `cep` pulses.
  - Writing `reg80`=0x01 mid-ACTIVE releases `int` on the next clock.
- Reset mid-OUT: assert `reset` while `iorq`=`wr`=0 at 0x82, release with `wr` still 0.
  - `reg82` stays 0x00.

Source files
------------

// File: rtl/lynx_io.sv
// lynx_io - Z80 I/O port block for the Lynx core.
// Decodes CPU I/O cycles, latches OUT writes to ports 0x80/0x82/0x84,
// returns keyboard column data on IN from port 0x80 and generates the
// active-low video-frame interrupt towards the CPU.
// The CPU interrupt request is named int_n because "int" is a reserved
// word in SystemVerilog.

module lynx_io #(
   parameter logic [7:0] INTLEN = 8'd32   // cep pulses int_n is held low (1..255)
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cep,
   input  logic        iorq,
   input  logic        wr,
   input  logic [15:0] a,
   input  logic [7:0]  d,
   output logic [7:0]  q,
   input  logic        vsync,
   output logic        int_n,
   output logic [3:0]  kbRow,
   input  logic [7:0]  kbCol,
   output logic [7:0]  reg80,
   output logic [7:0]  reg82,
   output logic [5:0]  speaker
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } int_state_t;

   // write-edge sampler
   logic       wr_prev_r;     // wr sampled at the previous cep
   logic       wr_armed_r;    // wr has been seen high at a cep since reset
   // vsync edge detector
   logic       vsync_prev_r;
   logic       vsync_rise_r;
   // port latches and read path
   logic [7:0] reg80_r;
   logic [7:0] reg82_r;
   logic [5:0] speaker_r;
   logic [3:0] kbrow_r;
   logic [7:0] q_r;
   // interrupt FSM
   int_state_t state_r;
   logic [7:0] cnt_r;
   logic       int_n_r;

   logic       port80_s;
   logic       ws_s;
   logic       mask_wr_s;
   logic       unused_addr_s;

   // Address decode, one-per-OUT write strobe and interrupt mask write detection
   always_comb begin
      port80_s      = (a[7:0] == 8'h80);
      ws_s          = cep & ~iorq & ~wr & wr_prev_r & wr_armed_r;
      mask_wr_s     = ws_s & port80_s & d[0];
      unused_addr_s = ^a[15:12];
   end

   // Sample wr on every cep; a write held through reset stays disarmed until wr is seen high
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_prev_r  <= 1'b1;
         wr_armed_r <= 1'b0;
      end else if (cep) begin
         wr_prev_r  <= wr;
         wr_armed_r <= wr_armed_r | wr;
      end else begin
         wr_prev_r  <= wr_prev_r;
         wr_armed_r <= wr_armed_r;
      end
   end

   // OUT latches for system control, bank switch and speaker DAC
   always_ff @(posedge clock) begin
      if (reset) begin
         reg80_r   <= 8'h00;
         reg82_r   <= 8'h00;
         speaker_r <= 6'd0;
      end else if (ws_s) begin
         case (a[7:0])
            8'h80:   reg80_r   <= d;
            8'h82:   reg82_r   <= d;
            8'h84:   speaker_r <= d[5:0];
            default: reg80_r   <= reg80_r;
         endcase
      end else begin
         reg80_r   <= reg80_r;
         reg82_r   <= reg82_r;
         speaker_r <= speaker_r;
      end
   end

   // Keyboard row select and IN data, updated every clock regardless of cep
   always_ff @(posedge clock) begin
      if (reset) begin
         kbrow_r <= 4'd0;
         q_r     <= 8'hFF;
      end else begin
         if (~iorq & port80_s) begin
            kbrow_r <= a[11:8];
         end else begin
            kbrow_r <= kbrow_r;
         end
         if (~iorq & wr & port80_s) begin
            q_r <= kbCol;
         end else begin
            q_r <= 8'hFF;
         end
      end
   end

   // Registered vsync rising-edge detector; reset value of 1 suppresses a false edge
   always_ff @(posedge clock) begin
      if (reset) begin
         vsync_prev_r <= 1'b1;
         vsync_rise_r <= 1'b0;
      end else begin
         vsync_prev_r <= vsync;
         vsync_rise_r <= vsync & ~vsync_prev_r;
      end
   end

   // Frame interrupt FSM: int_n low for INTLEN cep pulses, retriggerable, mask write wins
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= 8'd0;
         int_n_r <= 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (vsync_rise_r && !reg80_r[0] && !mask_wr_s) begin
                  state_r <= ST_ACTIVE;
                  cnt_r   <= INTLEN;
                  int_n_r <= 1'b0;
               end else begin
                  state_r <= ST_IDLE;
                  cnt_r   <= cnt_r;
                  int_n_r <= 1'b1;
               end
            end
            ST_ACTIVE: begin
               if (mask_wr_s) begin
                  state_r <= ST_IDLE;
                  cnt_r   <= 8'd0;
                  int_n_r <= 1'b1;
               end else if (vsync_rise_r) begin
                  state_r <= ST_ACTIVE;
                  cnt_r   <= INTLEN;
                  int_n_r <= 1'b0;
               end else if (cep) begin
                  if (cnt_r <= 8'd1) begin
                     state_r <= ST_IDLE;
                     cnt_r   <= 8'd0;
                     int_n_r <= 1'b1;
                  end else begin
                     state_r <= ST_ACTIVE;
                     cnt_r   <= cnt_r - 8'd1;
                     int_n_r <= 1'b0;
                  end
               end else begin
                  state_r <= ST_ACTIVE;
                  cnt_r   <= cnt_r;
                  int_n_r <= 1'b0;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= 8'd0;
               int_n_r <= 1'b1;
            end
         endcase
      end
   end

   assign q       = q_r;
   assign int_n   = int_n_r;
   assign kbRow   = kbrow_r;
   assign reg80   = reg80_r;
   assign reg82   = reg82_r;
   assign speaker = speaker_r;

endmodule
